// File: rtl/pe_ctrl.sv
// pe_ctrl: sequencer for one PE datapath (pe_dp).
// Walks a 4x4 window over an IMG_SIZE x IMG_SIZE image with step STRIDE,
// row-major. For each window it clears the accumulators and runs 16 MAC taps.
// It then latches the sum into one of four result lanes. Every fourth window,
// and after the last window, it writes the packed word to the result memory.
// Optional build macro: PE_CTRL_FILE_DUMP_EN. When defined, wr_file pulses in
// the FLUSH cycle. When undefined, wr_file is tied to 0 and pass timing is
// the same.
module pe_ctrl #(
  parameter int IMG_SIZE = 16,
  parameter int STRIDE   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       rst_acc,
  output logic       acc_en,
  output logic [7:0] buffer_cntr,
  output logic [7:0] img_buffer_index,
  output logic       res_buffer_en,
  output logic [7:0] res_index,
  output logic       rst_res_reg,
  output logic       wr_en,
  output logic [7:0] wr_adr,
  output logic       wr_file
);

  localparam int         OUT_DIM  = (IMG_SIZE - 4) / STRIDE + 1;
  localparam logic [7:0] LAST_RC  = 8'(OUT_DIM - 1);
  localparam logic [7:0] ROW_STEP = 8'(STRIDE * IMG_SIZE);
  localparam logic [7:0] COL_STEP = 8'(STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_MAC, S_STORE, S_WRITE, S_FLUSH, S_DONE
  } state_t;

  state_t     state;
  logic [7:0] win_r;
  logic [7:0] win_c;
  logic [3:0] tap;
  logic [1:0] lane;
  logic [7:0] word;
  logic       last_win;

  logic       is_last;
  logic [7:0] nxt_r;
  logic [7:0] nxt_c;
  logic [7:0] cur_index;
  logic [7:0] nxt_index;

  // Position of the following window and top-left pixel indices of the current and following windows
  always_comb begin
    is_last = (win_r == LAST_RC) && (win_c == LAST_RC);
    nxt_r   = win_r;
    nxt_c   = win_c + 8'd1;
    if (win_c == LAST_RC) begin
      nxt_c = 8'd0;
      nxt_r = win_r + 8'd1;
    end
    cur_index = win_r * ROW_STEP + win_c * COL_STEP;
    nxt_index = nxt_r * ROW_STEP + nxt_c * COL_STEP;
  end

`ifndef PE_CTRL_FILE_DUMP_EN
  assign wr_file = 1'b0;
`endif

  // FSM, counters and registered outputs. Outputs are loaded together with
  // the state they belong to, so they line up with the state cycle by cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      win_r            <= 8'd0;
      win_c            <= 8'd0;
      tap              <= 4'd0;
      lane             <= 2'd0;
      word             <= 8'd0;
      last_win         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      rst_acc          <= 1'b0;
      acc_en           <= 1'b0;
      buffer_cntr      <= 8'd0;
      img_buffer_index <= 8'd0;
      res_buffer_en    <= 1'b0;
      res_index        <= 8'd0;
      rst_res_reg      <= 1'b0;
      wr_en            <= 1'b0;
      wr_adr           <= 8'd0;
`ifdef PE_CTRL_FILE_DUMP_EN
      wr_file          <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless the next state sets them again
      rst_acc       <= 1'b0;
      acc_en        <= 1'b0;
      res_buffer_en <= 1'b0;
      rst_res_reg   <= 1'b0;
      wr_en         <= 1'b0;
      done          <= 1'b0;
      buffer_cntr   <= 8'd0;
      res_index     <= 8'd0;
      wr_adr        <= 8'd0;
`ifdef PE_CTRL_FILE_DUMP_EN
      wr_file       <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            state            <= S_CLR;
            busy             <= 1'b1;
            rst_acc          <= 1'b1;
            win_r            <= 8'd0;
            win_c            <= 8'd0;
            tap              <= 4'd0;
            lane             <= 2'd0;
            word             <= 8'd0;
            last_win         <= 1'b0;
            img_buffer_index <= 8'd0;
          end
        end
        S_CLR: begin
          state       <= S_MAC;
          tap         <= 4'd0;
          acc_en      <= 1'b1;
          buffer_cntr <= 8'd0;
        end
        S_MAC: begin
          if (tap == 4'd15) begin
            state         <= S_STORE;
            res_buffer_en <= 1'b1;
            res_index     <= {6'd0, lane};
          end else begin
            tap         <= tap + 4'd1;
            acc_en      <= 1'b1;
            buffer_cntr <= {4'd0, tap + 4'd1};
          end
        end
        S_STORE: begin
          last_win <= is_last;
          if (!is_last) begin
            win_r <= nxt_r;
            win_c <= nxt_c;
          end
          if (lane == 2'd3 || is_last) begin
            state       <= S_WRITE;
            wr_en       <= 1'b1;
            rst_res_reg <= 1'b1;
            wr_adr      <= word;
          end else begin
            state            <= S_CLR;
            rst_acc          <= 1'b1;
            lane             <= lane + 2'd1;
            img_buffer_index <= nxt_index;
          end
        end
        S_WRITE: begin
          word <= word + 8'd1;
          lane <= 2'd0;
          if (last_win) begin
            state            <= S_FLUSH;
            img_buffer_index <= 8'd0;
`ifdef PE_CTRL_FILE_DUMP_EN
            wr_file          <= 1'b1;
`endif
          end else begin
            // Window counters already advanced in STORE
            state            <= S_CLR;
            rst_acc          <= 1'b1;
            img_buffer_index <= cur_index;
          end
        end
        S_FLUSH: begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: directed bench for pe_ctrl.
// Instance a runs the default 16/4 configuration. Instance b runs IMG_SIZE=8
// with STRIDE=2. The sel signal picks which instance the pass monitor observes.
module tb_pe_ctrl;

`ifdef PE_CTRL_FILE_DUMP_EN
  localparam int EXP_WF = 1;
`else
  localparam int EXP_WF = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic sel;

  logic       a_busy, a_done, a_rst_acc, a_acc_en, a_res_buffer_en, a_rst_res_reg, a_wr_en, a_wr_file;
  logic [7:0] a_buffer_cntr, a_img_idx, a_res_index, a_wr_adr;
  logic       b_busy, b_done, b_rst_acc, b_acc_en, b_res_buffer_en, b_rst_res_reg, b_wr_en, b_wr_file;
  logic [7:0] b_buffer_cntr, b_img_idx, b_res_index, b_wr_adr;

  int vec_cnt = 0;
  int err_cnt = 0;
  int exp_idx [16];

  always #5 clk = ~clk;

  pe_ctrl u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(a_busy), .done(a_done),
    .rst_acc(a_rst_acc), .acc_en(a_acc_en), .buffer_cntr(a_buffer_cntr),
    .img_buffer_index(a_img_idx), .res_buffer_en(a_res_buffer_en),
    .res_index(a_res_index), .rst_res_reg(a_rst_res_reg), .wr_en(a_wr_en),
    .wr_adr(a_wr_adr), .wr_file(a_wr_file)
  );

  pe_ctrl #(.IMG_SIZE(8), .STRIDE(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(b_busy), .done(b_done),
    .rst_acc(b_rst_acc), .acc_en(b_acc_en), .buffer_cntr(b_buffer_cntr),
    .img_buffer_index(b_img_idx), .res_buffer_en(b_res_buffer_en),
    .res_index(b_res_index), .rst_res_reg(b_rst_res_reg), .wr_en(b_wr_en),
    .wr_adr(b_wr_adr), .wr_file(b_wr_file)
  );

  // Any output of an instance non-zero
  logic a_any, b_any;
  assign a_any = |{a_busy, a_done, a_rst_acc, a_acc_en, a_res_buffer_en, a_rst_res_reg,
                   a_wr_en, a_wr_file, a_buffer_cntr, a_img_idx, a_res_index, a_wr_adr};
  assign b_any = |{b_busy, b_done, b_rst_acc, b_acc_en, b_res_buffer_en, b_rst_res_reg,
                   b_wr_en, b_wr_file, b_buffer_cntr, b_img_idx, b_res_index, b_wr_adr};

  // Observed instance
  logic       o_busy, o_done, o_rst_acc, o_acc_en, o_res_buffer_en, o_rst_res_reg, o_wr_en, o_wr_file;
  logic [7:0] o_buffer_cntr, o_img_idx, o_res_index, o_wr_adr;
  assign o_busy          = sel ? b_busy          : a_busy;
  assign o_done          = sel ? b_done          : a_done;
  assign o_rst_acc       = sel ? b_rst_acc       : a_rst_acc;
  assign o_acc_en        = sel ? b_acc_en        : a_acc_en;
  assign o_res_buffer_en = sel ? b_res_buffer_en : a_res_buffer_en;
  assign o_rst_res_reg   = sel ? b_rst_res_reg   : a_rst_res_reg;
  assign o_wr_en         = sel ? b_wr_en         : a_wr_en;
  assign o_wr_file       = sel ? b_wr_file       : a_wr_file;
  assign o_buffer_cntr   = sel ? b_buffer_cntr   : a_buffer_cntr;
  assign o_img_idx       = sel ? b_img_idx       : a_img_idx;
  assign o_res_index     = sel ? b_res_index     : a_res_index;
  assign o_wr_adr        = sel ? b_wr_adr        : a_wr_adr;

  task automatic check(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // One full pass on the selected instance, checked cycle by cycle
  task automatic run_pass(input int nwin, input int exp_done, input bit hold);
    int cyc, win, taps, wr, wf, budget, nwr, exp_win;
    bit seen_done;
    nwr = (nwin + 3) / 4;
    set_start(1'b1);
    @(negedge clk);
    if (!hold) set_start(1'b0);
    check("first_clr", int'(o_rst_acc), 1);
    cyc = 1; win = 0; taps = 0; wr = 0; wf = 0; budget = 0; seen_done = 0;
    while (!seen_done && budget < 2000) begin
      if (o_rst_acc) begin
        check("win_idx", int'(o_img_idx), exp_idx[win % 16]);
        taps = 0;
      end
      if (o_acc_en) begin
        check("tap", int'(o_buffer_cntr), taps);
        check("tap_idx", int'(o_img_idx), exp_idx[win % 16]);
        taps++;
      end
      if (o_res_buffer_en) begin
        check("lane", int'(o_res_index), win % 4);
        check("taps_per_win", taps, 16);
        win++;
      end
      if (o_wr_en) begin
        exp_win = (wr < nwr - 1) ? 4 * (wr + 1) : nwin;
        check("wr_adr", int'(o_wr_adr), wr);
        check("rst_res", int'(o_rst_res_reg), 1);
        check("wr_after_win", win, exp_win);
        $display("write: sel=%0d adr=%0d after window %0d at cycle %0d", sel, o_wr_adr, win, cyc);
        wr++;
      end
      if (o_wr_file) begin
        wf++;
        check("wr_file_after_last_wr", wr, nwr);
      end
      check("one_strobe", int'($countones({o_rst_acc, o_acc_en, o_res_buffer_en, o_wr_en}) <= 1), 1);
      if (o_done) begin
        seen_done = 1;
        check("done_cycle", cyc, exp_done);
        check("busy_in_done", int'(o_busy), 0);
      end else begin
        check("busy", int'(o_busy), 1);
        @(negedge clk);
        cyc++;
        budget++;
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    check("n_windows", win, nwin);
    check("n_writes", wr, nwr);
    check("wr_file_pulses", wf, EXP_WF);
    $display("pass: sel=%0d windows=%0d writes=%0d done at cycle %0d", sel, win, wr, cyc);
    @(negedge clk);
    if (hold) set_start(1'b0);
    repeat (6) begin
      check("idle_after_pass", int'(o_busy | o_rst_acc | o_done), 0);
      @(negedge clk);
    end
  endtask

  task automatic load_idx_a;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        exp_idx[r * 4 + c] = r * 64 + c * 4;
  endtask

  initial begin
    int budget;
    rst = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    sel = 1'b0;

    // Reset held low with start asserted: everything stays zero
    repeat (4) begin
      @(negedge clk);
      check("rst_outs_a", int'(a_any), 0);
      check("rst_outs_b", int'(b_any), 0);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_rst", int'(a_any | b_any), 0);

    // Default pass: 16 windows, done 294 cycles counted from first CLR
    load_idx_a();
    run_pass(16, 294, 1'b0);

    // Start held through the pass and still high in DONE: exactly one pass
    run_pass(16, 294, 1'b1);
    run_pass(16, 294, 1'b0);

    // 8x8 image, stride 2: 9 windows, partial last word
    sel = 1'b1;
    exp_idx = '{0, 2, 4, 16, 18, 20, 32, 34, 36, 0, 0, 0, 0, 0, 0, 0};
    run_pass(9, 167, 1'b0);

    // Async reset in window 5 tap 7, then a clean restart
    sel = 1'b0;
    load_idx_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    budget = 0;
    while (!(a_acc_en && a_buffer_cntr == 8'd7 && a_img_idx == 8'd64) && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    check("reach_w5_t7", int'(budget < 1000), 1);
    #1 rst = 1'b0;
    #1 check("async_clear", int'(a_any), 0);
    @(negedge clk);
    check("held_clear", int'(a_any), 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_abort", int'(a_any), 0);
    run_pass(16, 294, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
